// File: rtl/segment_scan_mux.sv
// Multiplexed 7-segment scanner: NUM_PAIRS two-digit decimal fields over 2*NUM_PAIRS digits,
// with frame snapshot, PWM brightness, per-pair blink, leading-zero blanking and over-range dashes.
module segment_scan_mux #(
  parameter int unsigned NUM_PAIRS    = 2,
  parameter int unsigned SCAN_DIV     = 1024,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7*NUM_PAIRS-1:0] data_show,
  input  logic [2*NUM_PAIRS-1:0] digit_enable,
  input  logic [NUM_PAIRS-1:0]   blink_mask,
  input  logic [3:0]             brightness,
  input  logic                   lz_blank,
  output logic [2*NUM_PAIRS-1:0] digit_sel,
  output logic [6:0]             segment,
  output logic                   frame_start
);

  localparam int unsigned ND   = 2 * NUM_PAIRS;
  localparam int unsigned PH_W = $clog2(SCAN_DIV);
  localparam int unsigned SL_W = $clog2(ND);
  localparam int unsigned BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PH_W-1:0]        phase_q, phase_d;
  logic [SL_W-1:0]        slot_q, slot_d;
  logic [BC_W-1:0]        bcnt_q, bcnt_d;
  logic                   bphase_q, bphase_d;
  logic [7*NUM_PAIRS-1:0] shadow_q, shadow_d;
  logic [6:0]             seg_q, seg_d;
  logic [ND-1:0]          sel_q, sel_d;
  logic                   fs_q, fs_d;

  logic       phase_wrap, frame_wrap;
  logic [6:0] pv;
  logic       over;
  logic [3:0] tens, ones;
  logic [6:0] code;
  logic       lit;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h3f;
      4'd1:    c = 7'h06;
      4'd2:    c = 7'h5b;
      4'd3:    c = 7'h4f;
      4'd4:    c = 7'h66;
      4'd5:    c = 7'h6d;
      4'd6:    c = 7'h7d;
      4'd7:    c = 7'h07;
      4'd8:    c = 7'h7f;
      4'd9:    c = 7'h6f;
      default: c = 7'h00;
    endcase
    return c;
  endfunction

  always_comb begin
    phase_wrap = (phase_q == PH_W'(SCAN_DIV - 1));
    frame_wrap = phase_wrap && (slot_q == SL_W'(ND - 1));

    phase_d = phase_wrap ? '0 : phase_q + 1'b1;
    slot_d  = slot_q;
    if (phase_wrap) begin
      slot_d = frame_wrap ? '0 : slot_q + 1'b1;
    end

    shadow_d = shadow_q;
    bcnt_d   = bcnt_q;
    bphase_d = bphase_q;
    fs_d     = frame_wrap;
    if (frame_wrap) begin
      shadow_d = data_show;
      if (bcnt_q == BC_W'(BLINK_FRAMES - 1)) begin
        bcnt_d   = '0;
        bphase_d = ~bphase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end

    // Exactly one slot matches, so at most one select bit can go low.
    seg_d = '0;
    sel_d = '1;
    pv    = '0;
    over  = 1'b0;
    tens  = '0;
    ones  = '0;
    code  = '0;
    lit   = 1'b0;
    for (int unsigned k = 0; k < ND; k++) begin
      if (slot_q == SL_W'(k)) begin
        pv   = shadow_q[7*(k/2) +: 7];
        over = (pv > 7'd99);
        tens = 4'(pv / 7'd10);
        ones = 4'(pv % 7'd10);
        code = over ? 7'h40 : seg_code((k % 2 == 1) ? tens : ones);
        lit  = digit_enable[k]
            && !(blink_mask[k/2] && bphase_q)
            && !(lz_blank && (k % 2 == 1) && !over && (tens == 4'd0))
            && (phase_q != '0)
            && (phase_q[PH_W-1 -: 4] <= brightness);
        if (lit) begin
          sel_d[k] = 1'b0;
          seg_d    = code;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q  <= '0;
      slot_q   <= '0;
      bcnt_q   <= '0;
      bphase_q <= 1'b0;
      shadow_q <= '0;
      seg_q    <= '0;
      sel_q    <= '1;
      fs_q     <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      slot_q   <= slot_d;
      bcnt_q   <= bcnt_d;
      bphase_q <= bphase_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
      fs_q     <= fs_d;
    end
  end

  assign digit_sel   = sel_q;
  assign segment     = seg_q;
  assign frame_start = fs_q;

endmodule
